// File: rtl/matmul_stream.sv
// matmul_stream: NCH-lane signed int8 dot-product engine for a tflite
// fully-connected layer. One activation plus NCH weights are accepted per
// beat; the activation gets the input zero-point offset added before the
// multiply. Results are held on c_out until the consumer accepts them.
// Optional build macro: MATMUL_STREAM_RELU_EN clamps negative lanes of c_out
// to zero (the accumulators keep their raw values).
module matmul_stream #(
    parameter int P     = 8,
    parameter int NCH   = 4,
    parameter int MAX_K = 16,
    parameter int ACCW  = 32,
    parameter int KW    = $clog2(MAX_K + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    input  logic [8:0]            a_offset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [P-1:0]          a_in,
    input  logic [NCH*P-1:0]      w_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*ACCW-1:0]   c_out,
    output logic                  busy
);

    // Offset sum is 10 bits signed; the product of it with a P-bit weight
    // needs exactly P+10 bits.
    localparam int PW = P + 10;
    localparam logic [KW-1:0] MAX_K_L = KW'(MAX_K);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [KW-1:0]              k_q, k_d;
    logic [KW-1:0]              cnt_q, cnt_d;
    logic [8:0]                 off_q, off_d;
    logic [NCH-1:0][ACCW-1:0]   acc_q, acc_d;
    logic [NCH-1:0][ACCW-1:0]   acc_sum_s;
    logic [NCH*ACCW-1:0]        c_out_q, c_out_d;
    logic                       in_ready_q, out_valid_q, busy_q;
    logic [9:0]                 ofs_sum_s;
    logic [KW-1:0]              k_eff_s;
    logic [KW-1:0]              cnt_inc_s;

    // One lane multiply-accumulate; the product is exact in PW bits and is
    // sign-extended before the wrapping add.
    function automatic logic [ACCW-1:0] mac_lane(input logic [ACCW-1:0] acc,
                                                 input logic [9:0]      ofs,
                                                 input logic [P-1:0]    w);
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] w_ext;
        logic signed [PW-1:0] prod;
        a_ext = $signed({{P{ofs[9]}}, ofs});
        w_ext = $signed({{10{w[P-1]}}, w});
        prod  = a_ext * w_ext;
        return acc + {{(ACCW-PW){prod[PW-1]}}, prod};
    endfunction

    // Transform applied when an accumulator is published to c_out.
    function automatic logic [ACCW-1:0] out_xform(input logic [ACCW-1:0] v);
`ifdef MATMUL_STREAM_RELU_EN
        return v[ACCW-1] ? {ACCW{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    assign ofs_sum_s = {{(10-P){a_in[P-1]}}, a_in} + {off_q[8], off_q};
    assign k_eff_s   = (k_len > MAX_K_L) ? MAX_K_L : k_len;
    assign cnt_inc_s = cnt_q + KW'(1);

    // Per-lane candidate accumulator values for the current beat.
    always_comb begin
        acc_sum_s = acc_q;
        for (int j = 0; j < NCH; j++) begin
            acc_sum_s[j] = mac_lane(acc_q[j], ofs_sum_s, w_in[j*P +: P]);
        end
    end

    // Next-state and datapath update for the IDLE/ACC/OUT controller.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        acc_d   = acc_q;
        c_out_d = c_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d   = k_eff_s;
                    off_d = a_offset;
                    cnt_d = {KW{1'b0}};
                    acc_d = '0;
                    if (k_eff_s == {KW{1'b0}}) begin
                        // Empty dot product: publish zeros straight away.
                        c_out_d = {(NCH*ACCW){1'b0}};
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d = acc_sum_s;
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == k_q) begin
                        for (int j = 0; j < NCH; j++) begin
                            c_out_d[j*ACCW +: ACCW] = out_xform(acc_sum_s[j]);
                        end
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ACC;
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and handshake-flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= {KW{1'b0}};
            cnt_q       <= {KW{1'b0}};
            off_q       <= 9'd0;
            acc_q       <= '0;
            c_out_q     <= {(NCH*ACCW){1'b0}};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            acc_q       <= acc_d;
            c_out_q     <= c_out_d;
            in_ready_q  <= (state_d == S_ACC);
            out_valid_q <= (state_d == S_OUT);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_matmul_stream.sv
// Scoreboard bench for matmul_stream: stimulus pushes expected result vectors,
// a negedge monitor pops and compares them on every output handshake.
module tb_matmul_stream;
    localparam int P     = 8;
    localparam int NCH   = 4;
    localparam int MAX_K = 16;
    localparam int ACCW  = 32;
    localparam int KW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [KW-1:0]       k_len;
    logic [8:0]          a_offset;
    logic                in_valid;
    logic                in_ready;
    logic [P-1:0]        a_in;
    logic [NCH*P-1:0]    w_in;
    logic                out_valid;
    logic                out_ready;
    logic [NCH*ACCW-1:0] c_out;
    logic                busy;

    int total = 0;
    int bad   = 0;
    logic [NCH*ACCW-1:0] exp_q[$];
    logic [NCH*ACCW-1:0] mon_e;
    logic [NCH*ACCW-1:0] hold_e;

    always #5 clk = ~clk;

    matmul_stream #(.P(P), .NCH(NCH), .MAX_K(MAX_K), .ACCW(ACCW), .KW(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .a_offset(a_offset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .w_in(w_in), .out_valid(out_valid), .out_ready(out_ready),
        .c_out(c_out), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    function automatic logic [NCH*P-1:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
    endfunction

    function automatic logic [NCH*ACCW-1:0] pack_c(input int c0, input int c1, input int c2, input int c3);
        return {c3[31:0], c2[31:0], c1[31:0], c0[31:0]};
    endfunction

    // Monitor: compare every accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got c_out %0h want no output", c_out);
            end else begin
                mon_e = exp_q.pop_front();
                for (int j = 0; j < NCH; j++) begin
                    check($sformatf("lane%0d", j), {32'd0, c_out[j*ACCW +: ACCW]},
                          {32'd0, mon_e[j*ACCW +: ACCW]});
                end
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_start(input int k, input int off);
        start    = 1'b1;
        k_len    = k[KW-1:0];
        a_offset = off[8:0];
        step();
        start    = 1'b0;
    endtask

    task automatic beat(input int a, input logic [NCH*P-1:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got in_ready 0 want 1");
        end
        in_valid = 1'b1;
        a_in     = a[P-1:0];
        w_in     = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [NCH*P-1:0] wl;
        int lane1_exp;

        // Reset with random inputs.
        reset     = 1'b1;
        start     = 1'($urandom);
        k_len     = KW'($urandom);
        a_offset  = 9'($urandom);
        in_valid  = 1'($urandom);
        a_in      = 8'($urandom);
        w_in      = 32'($urandom);
        out_ready = 1'($urandom);
        step();
        start     = 1'($urandom);
        in_valid  = 1'($urandom);
        step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_c_out_lo", c_out[63:0], 64'd0);
        check("rst_c_out_hi", c_out[127:64], 64'd0);
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        k_len     = '0;
        a_offset  = 9'd0;
        step();

        // Basic run: lanes weight j+1, activations 1,2,3.
        wl = pack_w(1, 2, 3, 4);
        exp_q.push_back(pack_c(6, 12, 18, 24));
        run_start(3, 0);
        check("basic_in_ready", {63'd0, in_ready}, 64'd1);
        beat(1, wl);
        beat(2, wl);
        check("basic_early_valid", {63'd0, out_valid}, 64'd0);
        beat(3, wl);
        check("basic_latency", {63'd0, out_valid}, 64'd1);
        wait_idle("basic_idle");

        // Signed extremes with offset.
`ifdef MATMUL_STREAM_RELU_EN
        lane1_exp = 0;
`else
        lane1_exp = -255;
`endif
        exp_q.push_back(pack_c(32512, lane1_exp, 0, 0));
        run_start(2, 1);
        beat(-128, pack_w(-128, 1, 0, 0));
        beat(127, pack_w(127, -1, 0, 0));
        wait_idle("signed_idle");

        // Input gap, then output backpressure with an ignored start.
        hold_e = pack_c(10, 20, 30, 40);
        exp_q.push_back(hold_e);
        run_start(4, 0);
        beat(1, wl);
        beat(2, wl);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("gap_no_output", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;
        beat(3, wl);
        beat(4, wl);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid_held", {63'd0, out_valid}, 64'd1);
            check("bp_c_out_lo", c_out[63:0], hold_e[63:0]);
            check("bp_c_out_hi", c_out[127:64], hold_e[127:64]);
            start = (i == 2);
            k_len = 5'd3;
            step();
            start = 1'b0;
        end
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start     = 1'b0;
        check("bp_release_idle", {63'd0, busy}, 64'd0);
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_retained_lo", c_out[63:0], hold_e[63:0]);
        step();
        check("bp_start_ignored", {63'd0, busy}, 64'd0);

        // Zero depth.
        exp_q.push_back(pack_c(0, 0, 0, 0));
        run_start(0, 0);
        check("k0_valid", {63'd0, out_valid}, 64'd1);
        check("k0_in_ready", {63'd0, in_ready}, 64'd0);
        wait_idle("k0_idle");
        check("k0_in_ready_after", {63'd0, in_ready}, 64'd0);

        // Reset mid-run, then a clean single-beat run.
        run_start(5, 0);
        beat(7, pack_w(9, 9, 9, 9));
        beat(7, pack_w(9, 9, 9, 9));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_c_out_lo", c_out[63:0], 64'd0);
        check("midrst_c_out_hi", c_out[127:64], 64'd0);
        exp_q.push_back(pack_c(15, 0, 0, 0));
        run_start(1, 0);
        beat(5, pack_w(3, 0, 0, 0));
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        wait_idle("post_rst_idle");

        step();
        step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matmul_stream.md
Name: matmul_stream

Overview:
- Parametrised successor to the fixed 4-channel matmul engine.
- Computes NCH parallel int8 dot products (one output channel per lane) over a runtime-selectable depth k_len, for a fully-connected layer in the tflite inference path.
- Streams one activation plus NCH weights per beat through a valid/ready handshake.
- Applies the tflite input zero-point offset and holds the int32 results until the consumer accepts them.

Parameters:
- P, 8, operand width (signed activations and weights).
- NCH, 4, number of output channels / lanes.
- MAX_K, 16, maximum dot-product depth.
- ACCW, 32, accumulator and result width per lane.
- KW, $clog2(MAX_K+1), width of k_len.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run, honoured only in IDLE.
- k_len  in  KW  dot-product depth, sampled on start; legal range 0..MAX_K.
- a_offset  in  9  signed input offset, added to every a_in; sampled on start.
- in_valid  in  1  a_in/w_in beat valid.
- in_ready  out  1  engine accepts a beat.
- a_in  in  P  signed activation.
- w_in  in  NCH*P  signed weights; lane j = w_in[j*P +: P].
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.
- c_out  out  NCH*ACCW  signed results; lane j = c_out[j*ACCW +: ACCW].
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (sampled on posedge when reset=1):
  - state to IDLE.
  - in_ready, out_valid, busy = 0.
  - c_out, all accumulators, beat counter, latched k_len and a_offset = 0.
  - Reset overrides every other input in the same cycle, including mid-run: no partial result is ever presented.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 with k_len>0: latch k_len and a_offset, clear accumulators and counter, go to ACC.
  - start=1 with k_len=0: clear accumulators, go directly to OUT; results are all zero.
  - k_len>MAX_K is illegal; the engine clamps it to MAX_K.
- ACC:
  - in_ready=1 (combinational on state only, never on in_valid).
  - Each handshake (in_valid & in_ready): acc[j] <= acc[j] + (sext(a_in)+a_offset) * sext(w_in lane j) for all j; counter++.
  - A cycle without in_valid leaves acc and counter unchanged.
  - When the accepted beat is beat number k_len: go to OUT.
- OUT:
  - out_valid=1 from the cycle after the last accepted beat (one-cycle latency).
  - c_out is registered from acc and is stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: go to IDLE next cycle. out_valid drops and c_out retains its last value.
- start is ignored in ACC and OUT, and in the cycle of the output handshake. A new run needs start while in IDLE.
- Arithmetic:
  - Offset sum is a 10-bit signed value.
  - Product is 10+P bits signed, sign-extended to ACCW.
  - Accumulation wraps modulo 2^ACCW; no saturation.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: MATMUL_STREAM_RELU_EN.
- Defined: the value registered into c_out is max(acc[j],0) per lane. Negative lanes read 0 and the accumulators themselves are unaffected.
- Undefined: c_out is the raw accumulator. No clamp logic is generated.

Test Plan:
- Reset: hold reset=1 for 2 cycles with random inputs -> in_ready=0, out_valid=0, busy=0, c_out=0.
- Basic run: NCH=4, k_len=3, a_offset=0, a_in=1,2,3, every lane j weight=j+1 on each beat, in_valid continuous -> out_valid high one cycle after beat 3, c_out lanes = 6,12,18,24.
- Signed/offset: k_len=2, a_offset=1, a_in=-128 then 127, lane0 weights -128 then 127 -> lane0 = 32512. With the same beats and lane1 weights 1 then -1 -> lane1 = -255 (0 with MATMUL_STREAM_RELU_EN).
- Backpressure:
  - k_len=4 with in_valid deasserted for 3 cycles between beats 2 and 3 -> same result as a gapless run.
  - Then out_ready=0 for 5 cycles with start pulsed -> c_out stable, out_valid held, start ignored.
  - out_ready=1 -> IDLE next cycle.
- Zero depth: start with k_len=0 -> out_valid asserted the next cycle, all lanes 0, in_ready never asserted.
- Reset mid-run: k_len=5, reset after 2 beats -> IDLE with zeros. Then new run k_len=1, a_in=5, lane0 weight=3 -> lane0 = 15 (no residue from the aborted run).
